// File: rtl/pipe_stage_reg.sv
// Two-entry pipeline stage register (main + skid) carrying MIPS-style hazard metadata.
// Outputs come straight from the main register; the skid entry absorbs one beat of backpressure.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int TNEW_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_pc,
  input  logic [31:0]       in_instr,
  input  logic [4:0]        in_exc,
  input  logic [4:0]        in_wa,
  input  logic [TNEW_W-1:0] in_tnew,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_pc,
  output logic [31:0]       out_instr,
  output logic [4:0]        out_exc,
  output logic [4:0]        out_wa,
  output logic [TNEW_W-1:0] out_tnew,
  output logic [DATA_W-1:0] out_data
);

  typedef struct packed {
    logic [31:0]       pc;
    logic [31:0]       instr;
    logic [4:0]        exc;
    logic [4:0]        wa;
    logic [TNEW_W-1:0] tnew;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t m_q, m_d, s_q, s_d;
  logic   m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  entry_t in_e;
  logic   in_fire, out_fire;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - TNEW_W'(1);
  endfunction

  function automatic entry_t age(input entry_t e);
    entry_t r;
    r      = e;
    r.tnew = tnew_dec(e.tnew);
    return r;
  endfunction

  assign in_ready = ~s_vld_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_vld_q & out_ready;

  // A faulting instruction must never write the register file.
  always_comb begin
    in_e.pc    = in_pc;
    in_e.instr = in_instr;
    in_e.exc   = in_exc;
    in_e.wa    = (in_exc != 5'd0) ? 5'd0 : in_wa;
    in_e.tnew  = tnew_dec(in_tnew);
    in_e.data  = in_data;
  end

  always_comb begin
    m_d     = m_q;
    s_d     = s_q;
    m_vld_d = m_vld_q;
    s_vld_d = s_vld_q;
    if (flush) begin
      m_d     = '0;
      s_d     = '0;
      m_vld_d = 1'b0;
      s_vld_d = 1'b0;
    end else if (!m_vld_q || out_fire) begin
      // in_fire cannot coincide with a valid skid entry since in_ready is low then.
      if (s_vld_q) begin
        m_d     = age(s_q);
        m_vld_d = 1'b1;
        s_d     = '0;
        s_vld_d = 1'b0;
      end else if (in_fire) begin
        m_d     = in_e;
        m_vld_d = 1'b1;
      end else begin
        m_d     = '0;
        m_vld_d = 1'b0;
      end
    end else begin
      m_d = age(m_q);
      if (s_vld_q) begin
        s_d = age(s_q);
      end else if (in_fire) begin
        s_d     = in_e;
        s_vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q     <= '0;
      s_q     <= '0;
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
    end else begin
      m_q     <= m_d;
      s_q     <= s_d;
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
    end
  end

  // Empty main register is held all-zero, so a bubble reads as a nop.
  assign out_valid = m_vld_q;
  assign out_pc    = m_q.pc;
  assign out_instr = m_q.instr;
  assign out_exc   = m_q.exc;
  assign out_wa    = m_q.wa;
  assign out_tnew  = m_q.tnew;
  assign out_data  = m_q.data;

endmodule
